// File: rtl/cnn_pkg.sv
// Shared CNN datapath definitions: sample format and collector FSM states.
// Used by the pooling, collector and conv blocks.
package cnn_pkg;

    localparam int DATA_W  = 16;
    localparam int MAX_OUT = 16;

    // Signed Q5.10, 16'h0400 = 1.0
    typedef logic signed [15:0] sample_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_e;

endpackage

// File: rtl/pool_relu.sv
// Combinational ReLU on a signed sample; a pass-through when APPLY_RELU is 0.
// Decides on the sign bit alone and never rescales.
module pool_relu #(
    parameter int DATA_W     = 16,
    parameter int APPLY_RELU = 0
) (
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    always_comb begin
        dout = din;
        if ((APPLY_RELU != 0) && din[DATA_W-1]) begin
            dout = '0;
        end
    end

endmodule

// File: rtl/pool_map_collector.sv
// Assembles the raster-order pooled stream into a full feature map and holds it
// stable for the next conv layer until the following legal start.
module pool_map_collector #(
    parameter int DATA_W     = cnn_pkg::DATA_W,
    parameter int MAX_OUT    = cnn_pkg::MAX_OUT,
    parameter int APPLY_RELU = 0
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic [15:0]                       outSize,
    input  logic                              in_valid,
    input  logic signed [DATA_W-1:0]          in_data,
    output logic                              in_ready,
    output logic [MAX_OUT*MAX_OUT*DATA_W-1:0] featureMap,
    output logic                              busy,
    output logic                              done,
    output logic                              size_err
);

    import cnn_pkg::*;

    localparam int          MAP_N   = MAX_OUT * MAX_OUT;
    localparam int          IDX_W   = $clog2(MAP_N);
    localparam logic [15:0] MAP_N16 = 16'(MAP_N);
    localparam logic [15:0] MAX16   = 16'(MAX_OUT);

    state_e             state_q;
    logic [15:0]        sz_q;
    logic [15:0]        row_q;
    logic [15:0]        col_q;
    logic [DATA_W-1:0]  map_q [MAP_N];

    logic [15:0]        idx;
    logic [DATA_W-1:0]  wr_data;
    logic               size_ok;
    logic               last_col;
    logic               last_row;
    logic               xfer;

    pool_relu #(
        .DATA_W    (DATA_W),
        .APPLY_RELU(APPLY_RELU)
    ) u_relu (
        .din (in_data),
        .dout(wr_data)
    );

    // 16-bit unsigned product; wrap is impossible for legal sizes.
    assign idx      = row_q * sz_q + col_q;
    assign size_ok  = (outSize != 16'd0) && (outSize <= MAX16);
    assign last_col = (col_q == sz_q - 16'd1);
    assign last_row = (row_q == sz_q - 16'd1);

    assign in_ready = (state_q == COLLECT);
    assign busy     = (state_q == COLLECT);
    assign done     = (state_q == DONE);
    assign xfer     = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            sz_q     <= '0;
            row_q    <= '0;
            col_q    <= '0;
            size_err <= 1'b0;
            for (int i = 0; i < MAP_N; i++) begin
                map_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (size_ok) begin
                            sz_q     <= outSize;
                            row_q    <= '0;
                            col_q    <= '0;
                            size_err <= 1'b0;
                            state_q  <= COLLECT;
                            for (int i = 0; i < MAP_N; i++) begin
                                map_q[i] <= '0;
                            end
                        end else begin
                            size_err <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (xfer) begin
                        if (idx < MAP_N16) begin
                            map_q[idx[IDX_W-1:0]] <= wr_data;
                        end
                        if (last_col) begin
                            col_q <= '0;
                            row_q <= row_q + 16'd1;
                            if (last_row) begin
                                state_q <= DONE;
                            end
                        end else begin
                            col_q <= col_q + 16'd1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        featureMap = '0;
        for (int i = 0; i < MAP_N; i++) begin
            featureMap[i*DATA_W +: DATA_W] = map_q[i];
        end
    end

endmodule

// File: tb/tb_pool_map_collector.sv
// Directed bench for pool_map_collector: a ReLU-off and a ReLU-on instance share
// stimulus and are compared every cycle against a sample-count model.
module tb_pool_map_collector;

    localparam int DW   = 16;
    localparam int MO   = 16;
    localparam int N    = MO * MO;
    localparam int MAPW = N * DW;

    logic               clk      = 1'b0;
    logic               reset    = 1'b1;
    logic               start    = 1'b0;
    logic [15:0]        outSize  = 16'd0;
    logic               in_valid = 1'b0;
    logic signed [15:0] in_data  = 16'sd0;

    logic            ready0, busy0, done0, err0;
    logic            ready1, busy1, done1, err1;
    logic [MAPW-1:0] fm0, fm1;

    pool_map_collector #(.DATA_W(DW), .MAX_OUT(MO), .APPLY_RELU(0)) dut0 (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .outSize   (outSize),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (ready0),
        .featureMap(fm0),
        .busy      (busy0),
        .done      (done0),
        .size_err  (err0)
    );

    pool_map_collector #(.DATA_W(DW), .MAX_OUT(MO), .APPLY_RELU(1)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .outSize   (outSize),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (ready1),
        .featureMap(fm1),
        .busy      (busy1),
        .done      (done1),
        .size_err  (err1)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;
    bit cmp_en   = 1'b0;

    // Model: phase 0 idle, 1 collecting, 2 done; map index is simply the sample count.
    int          m_phase = 0;
    int          m_count = 0;
    int          m_sz    = 0;
    bit          m_err   = 1'b0;
    logic [15:0] exp0 [N];
    logic [15:0] exp1 [N];

    initial begin
        for (int i = 0; i < N; i++) begin
            exp0[i] = 16'h0;
            exp1[i] = 16'h0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic chk_map(input string name, input logic [MAPW-1:0] fm, input bit relu);
        int bad;
        logic [15:0] e;
        bad = -1;
        for (int i = 0; i < N; i++) begin
            e = relu ? exp1[i] : exp0[i];
            if (bad < 0 && fm[i*DW +: DW] !== e) bad = i;
        end
        checks++;
        if (bad >= 0) begin
            errors++;
            e = relu ? exp1[bad] : exp0[bad];
            $display("FAIL %s[%0d]: got %h expected %h", name, bad, fm[bad*DW +: DW], e);
        end
    endtask

    function automatic logic [15:0] ent(input logic [MAPW-1:0] fm, input int i);
        return fm[i*DW +: DW];
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_phase = 0;
            m_count = 0;
            m_err   = 1'b0;
            for (int i = 0; i < N; i++) begin
                exp0[i] = 16'h0;
                exp1[i] = 16'h0;
            end
        end else if (m_phase == 0) begin
            if (start) begin
                if (outSize >= 16'd1 && outSize <= 16'(MO)) begin
                    m_sz    = int'(outSize);
                    m_count = 0;
                    m_err   = 1'b0;
                    m_phase = 1;
                    for (int i = 0; i < N; i++) begin
                        exp0[i] = 16'h0;
                        exp1[i] = 16'h0;
                    end
                end else begin
                    m_err = 1'b1;
                end
            end
        end else if (m_phase == 1) begin
            if (in_valid) begin
                exp0[m_count] = in_data;
                exp1[m_count] = in_data[15] ? 16'h0 : in_data;
                m_count++;
                if (m_count == m_sz * m_sz) m_phase = 2;
            end
        end else begin
            m_phase = 0;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("ready0", 32'(ready0), 32'(m_phase == 1));
            chk("busy0",  32'(busy0),  32'(m_phase == 1));
            chk("done0",  32'(done0),  32'(m_phase == 2));
            chk("err0",   32'(err0),   32'(m_err));
            chk("ready1", 32'(ready1), 32'(m_phase == 1));
            chk("busy1",  32'(busy1),  32'(m_phase == 1));
            chk("done1",  32'(done1),  32'(m_phase == 2));
            chk("err1",   32'(err1),   32'(m_err));
            chk_map("map0", fm0, 1'b0);
            chk_map("map1", fm1, 1'b1);
            if (done0) done_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_frame(input logic [15:0] sz);
        start   = 1'b1;
        outSize = sz;
        step();
        start   = 1'b0;
    endtask

    task automatic feed(input logic [15:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
    endtask

    logic [15:0] d3 [4];
    int          dc_before;

    initial begin
        d3[0] = 16'hFC00;
        d3[1] = 16'h0400;
        d3[2] = 16'h8000;
        d3[3] = 16'h0C00;

        // Reset state
        step();
        cmp_en = 1'b1;
        step();
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_err", 32'(err0), 32'd0);
        chk("rst_map0", 32'(ent(fm0, 0)), 32'h0);
        reset = 1'b0;
        step();

        // 1: reset mid-frame
        dc_before = done_cnt;
        begin_frame(16'd4);
        for (int i = 0; i < 5; i++) feed(16'(16'h0101 * (i + 1)));
        chk("t1_partial", 32'(ent(fm0, 4)), 32'h0505);
        in_valid = 1'b0;
        reset    = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) chk("t1_zero", 32'(ent(fm0, i)), 32'h0);
        chk("t1_busy", 32'(busy0), 32'd0);
        step();
        step();
        chk("t1_nodone", 32'(done_cnt - dc_before), 32'd0);

        // 2: full 4x4 frame, in_valid left high through DONE and IDLE
        dc_before = done_cnt;
        begin_frame(16'd4);
        for (int k = 0; k < 16; k++) feed(16'(k * 16'h0400));
        chk("t2_done", 32'(done0), 32'd1);
        in_data = 16'h7777;
        step();
        chk("t2_done_low", 32'(done0), 32'd0);
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 16; k++) chk("t2_map", 32'(ent(fm0, k)), 32'(k * 16'h0400));
        chk("t2_e16", 32'(ent(fm0, 16)), 32'h0);
        chk("t2_e255", 32'(ent(fm0, 255)), 32'h0);
        chk("t2_done_once", 32'(done_cnt - dc_before), 32'd1);

        // 3: bubbles with ReLU; an IDLE in_valid first must be dropped
        feed(16'h1234);
        in_valid = 1'b0;
        begin_frame(16'd2);
        for (int i = 0; i < 4; i++) begin
            feed(d3[i]);
            if (i == 3) begin
                chk("t3_done0", 32'(done0), 32'd1);
                chk("t3_done1", 32'(done1), 32'd1);
            end
            in_valid = 1'b0;
            step();
        end
        chk("t3_r0", 32'(ent(fm1, 0)), 32'h0);
        chk("t3_r1", 32'(ent(fm1, 1)), 32'h0400);
        chk("t3_r2", 32'(ent(fm1, 2)), 32'h0);
        chk("t3_r3", 32'(ent(fm1, 3)), 32'h0C00);
        chk("t3_p0", 32'(ent(fm0, 0)), 32'hFC00);
        chk("t3_p2", 32'(ent(fm0, 2)), 32'h8000);

        // 4: illegal sizes
        start   = 1'b1;
        outSize = 16'd0;
        step();
        chk("t4_err0", 32'(err0), 32'd1);
        chk("t4_busy0", 32'(busy0), 32'd0);
        outSize = 16'd17;
        step();
        chk("t4_err17", 32'(err0), 32'd1);
        outSize = 16'd2;
        step();
        start = 1'b0;
        chk("t4_err_clr", 32'(err0), 32'd0);
        chk("t4_busy", 32'(busy0), 32'd1);
        for (int i = 0; i < 4; i++) feed(16'(i + 1));
        in_valid = 1'b0;
        step();

        // 5: start ignored in COLLECT and DONE
        begin_frame(16'd2);
        feed(16'h0100);
        start   = 1'b1;
        outSize = 16'd3;
        feed(16'h0200);
        start = 1'b0;
        feed(16'h0300);
        feed(16'h0400);
        in_valid = 1'b0;
        chk("t5_in_done", 32'(done0), 32'd1);
        start   = 1'b1;
        outSize = 16'd2;
        step();
        start = 1'b0;
        chk("t5_busy", 32'(busy0), 32'd0);
        chk("t5_kept", 32'(ent(fm0, 2)), 32'h0300);
        step();
        begin_frame(16'd2);
        chk("t5_restart", 32'(busy0), 32'd1);
        chk("t5_cleared", 32'(ent(fm0, 0)), 32'h0);
        for (int i = 0; i < 4; i++) feed(16'(16'h0011 * (i + 1)));
        in_valid = 1'b0;
        chk("t5_new", 32'(ent(fm0, 3)), 32'h0044);
        step();

        // 6: single-sample frame
        begin_frame(16'd1);
        feed(16'h7FFF);
        in_valid = 1'b0;
        chk("t6_done", 32'(done0), 32'd1);
        chk("t6_map0", 32'(ent(fm0, 0)), 32'h7FFF);
        chk("t6_map1", 32'(ent(fm1, 0)), 32'h7FFF);
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
